mem_access_unit: RTL

- Load/store unit between the mips core's memory request signals and the data_ram port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Generates word-aligned RAM address, byte-lane write enables and replicated write data; waits out the RAM read latency.
- Extracts and sign/zero-extends load data. Flags misaligned accesses without touching RAM.

---
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the core's request handshake and a single data_ram port.
// Handles lane masks, store replication, read-latency wait, load extraction and misalignment errors.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | RAM address/enable cycle (write happens here for stores)
// WAIT   | load waiting out RD_LATENCY cycles, address held
// RESP   | one-cycle completion pulse
module mem_access_unit #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        ram_ena,
    output logic [3:0]  ram_wea,
    output logic [31:0] ram_addra,
    output logic [31:0] ram_dina,
    input  logic [31:0] ram_douta
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t      state;
    logic [2:0]  cnt;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [1:0]  lat_off;

    logic        req_err;
    logic [3:0]  lane_mask;
    logic [31:0] wdata_rep;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE) && rst;

    always_comb begin
        req_err   = 1'b0;
        lane_mask = 4'b1111;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                lane_mask = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_err   = req_addr[0];
                lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel  = ram_douta[{lat_off, 3'b000} +: 8];
        half_sel  = lat_off[1] ? ram_douta[31:16] : ram_douta[15:0];
        load_data = ram_douta;
        case (lat_size)
            2'b00:   load_data = lat_uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = lat_uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = ram_douta;
        endcase
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_off    <= 2'b00;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            ram_ena    <= 1'b0;
            ram_wea    <= 4'b0000;
            ram_addra  <= 32'h0;
            ram_dina   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we   <= req_we;
                        lat_size <= req_size;
                        lat_uns  <= req_unsigned;
                        lat_off  <= req_addr[1:0];
                        busy     <= 1'b1;
                        if (req_err) begin
                            // Errors never reach the RAM; respond straight away.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= ACCESS;
                            ram_ena   <= 1'b1;
                            ram_addra <= {req_addr[31:2], 2'b00};
                            ram_wea   <= req_we ? lane_mask : 4'b0000;
                            ram_dina  <= req_we ? wdata_rep : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        state      <= RESP;
                        ram_ena    <= 1'b0;
                        ram_wea    <= 4'b0000;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                    end else begin
                        state <= WAIT;
                        cnt   <= LAT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        state      <= RESP;
                        cnt        <= 3'd0;
                        ram_ena    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
